bin2bcd_seq: RTL

//   Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).

---
 rtl/bin2bcd_seq_if.sv | 33 +++
 rtl/bin2bcd_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bus between a binary source and the bin2bcd_seq converter.
// The master issues start/bin; the slave (converter) returns ready/valid/bcd/overflow.
interface bin2bcd_seq_if #(
   parameter int unsigned IN_BITS    = 16,
   parameter int unsigned NUM_DIGITS = 5
) ();

   logic                      in_start;
   logic [IN_BITS-1:0]        in_bin;
   logic                      out_ready;
   logic                      out_valid;
   logic [4*NUM_DIGITS-1:0]   out_bcd;
   logic                      out_overflow;

   modport master (
      output in_start,
      output in_bin,
      input  out_ready,
      input  out_valid,
      input  out_bcd,
      input  out_overflow
   );

   modport slave (
      input  in_start,
      input  in_bin,
      output out_ready,
      output out_valid,
      output out_bcd,
      output out_overflow
   );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: shift-and-add-3, one input bit per clock,
// a single add-3 stage per digit reused over IN_BITS cycles.
module bin2bcd_seq #(
   parameter int unsigned IN_BITS    = 16,
   parameter int unsigned NUM_DIGITS = 5
) (
   input  logic          in_clk,
   input  logic          in_rst,
   bin2bcd_seq_if.slave  bus
);

   localparam int unsigned AW = 4 * NUM_DIGITS;
   localparam int unsigned CW = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e              state_q;
   state_e              state_d;

   logic [IN_BITS-1:0]  shreg_q;
   logic [AW-1:0]       acc_q;
   logic [CW-1:0]       cnt_q;
   logic                ovf_q;

   logic [AW-1:0]       bcd_q;
   logic                ovf_out_q;
   logic                ready_q;
   logic                valid_q;

   logic                ready_d;
   logic                valid_d;

   logic [AW-1:0]       acc_adj;
   logic [AW-1:0]       acc_shl;
   logic [IN_BITS-1:0]  shreg_shl;
   logic                carry;
   logic                accept;
   logic                last_shift;

   assign accept     = (state_q == S_IDLE) && bus.in_start;
   assign last_shift = (state_q == S_SHIFT) && (cnt_q == CW'(IN_BITS - 1));

   // Add-3 correction on every digit that would reach 10 or more after doubling.
   always_comb begin
      acc_adj = acc_q;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // The bit leaving the top digit is a lost decimal carry, i.e. overflow.
   assign {carry, acc_shl} = {acc_adj, shreg_q[IN_BITS-1]};
   assign shreg_shl        = shreg_q << 1;

   // State register.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (bus.in_start) state_d = S_SHIFT;
         S_SHIFT: if (last_shift)   state_d = S_DONE;
         S_DONE:                    state_d = S_IDLE;
         default:                   state_d = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state, so the handshake flops line up with it.
   always_comb begin
      ready_d = 1'b0;
      valid_d = 1'b0;
      unique case (state_d)
         S_IDLE:  ready_d = 1'b1;
         S_SHIFT: ready_d = 1'b0;
         S_DONE:  valid_d = 1'b1;
         default: ready_d = 1'b1;
      endcase
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         ready_q <= ready_d;
         valid_q <= valid_d;
      end
   end

   // Working registers: load on accepted start, iterate while shifting.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         shreg_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         shreg_q <= bus.in_bin;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else if (state_q == S_SHIFT) begin
         shreg_q <= shreg_shl;
         acc_q   <= acc_shl;
         cnt_q   <= cnt_q + CW'(1);
         ovf_q   <= ovf_q | carry;
      end
   end

   // Result holds until the final shift of the next conversion.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         bcd_q     <= '0;
         ovf_out_q <= 1'b0;
      end else if (last_shift) begin
         bcd_q     <= acc_shl;
         ovf_out_q <= ovf_q | carry;
      end
   end

   assign bus.out_ready    = ready_q;
   assign bus.out_valid    = valid_q;
   assign bus.out_bcd      = bcd_q;
   assign bus.out_overflow = ovf_out_q;

endmodule
